// File: rtl/ioctl_ram_arbiter.sv
// ioctl_ram_arbiter
//   Shares one single-port overlay RAM between the HPS ioctl download stream
//   and the pixel-side fetch requester. Download bytes are queued in a small
//   FIFO and drained into RAM whenever video is not reading. ioctl_wait
//   throttles the loader. dl_done pulses once a download has fully landed.
//
// Optional feature (compile-time macro IOCTL_RAM_ARB_STARVE_GUARD_EN):
//   After MAX_STARVE consecutive video grants while writes are pending, one
//   write is forced through. Without the macro, video has strict priority.
//
// Ports
//   clk_sys, reset         clock (rising edge), async active-high reset
//   ioctl_download/wr/addr/dout/index   loader stream in
//   ioctl_wait             registered backpressure to the loader
//   vid_req/vid_addr       video read request (level, held until vid_ack)
//   vid_ack                read issued to RAM this cycle
//   vid_rdata/vid_rvalid   read return, RAM_LAT cycles after vid_ack
//   ram_addr/we/wdata/rdata   single-port RAM
//   dl_done                one-cycle pulse when an accepted download is in RAM
//   dl_overflow            sticky, set when a byte was dropped on a full FIFO
module ioctl_ram_arbiter #(
  parameter int         ADDR_W     = 16,
  parameter int         DATA_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter int         RAM_LAT    = 1,
  parameter logic [7:0] DL_INDEX   = 8'd0,
  parameter int         MAX_STARVE = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dl_done,
  output logic              dl_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(MAX_STARVE + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_WAIT = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [STV_W-1:0] STV_ZERO = {STV_W{1'b0}};
  localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1'b1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_STARVE);

`ifdef IOCTL_RAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wait_q, wait_d;
  logic                ovf_q, ovf_d;
  logic                dl_prev_q;
  logic                got_data_q, got_data_d;
  logic [ADDR_W-1:0]   last_addr_q;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [RAM_LAT-1:0]  rv_q, rv_d;
  logic [STV_W-1:0]    starve_q, starve_d;

  logic                accept_s, idx_match_s, rise_s;
  logic                fifo_empty_s, fifo_full_s;
  logic                force_wr_s, vid_grant_s, pop_s, push_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [DATA_W-1:0]   ram_wdata_s;

  // Arbitration, FIFO bookkeeping and RAM port drive
  always_comb begin
    idx_match_s  = (ioctl_index == DL_INDEX);
    accept_s     = ioctl_wr && ioctl_download && idx_match_s &&
                   ((ioctl_addr >> ADDR_W) == 25'd0);
    rise_s       = ioctl_download && !dl_prev_q;
    fifo_empty_s = (count_q == CNT_ZERO);
    fifo_full_s  = (count_q == CNT_FULL);
    force_wr_s   = GUARD_EN && !fifo_empty_s && (starve_q == STV_MAX);
    vid_grant_s  = vid_req && !force_wr_s;
    pop_s        = !vid_grant_s && !fifo_empty_s;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    push_s       = accept_s && (!fifo_full_s || pop_s);
    ovf_d        = ovf_q || (accept_s && fifo_full_s && !pop_s);

    ram_addr_s  = last_addr_q;
    ram_wdata_s = {DATA_W{1'b0}};
    if (vid_grant_s) begin
      ram_addr_s = vid_addr;
    end else if (pop_s) begin
      ram_addr_s  = fifo_addr_q[rd_ptr_q];
      ram_wdata_s = fifo_data_q[rd_ptr_q];
    end else begin
      ram_addr_s = last_addr_q;
    end

    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Raised one slot early so a strobe already in flight still fits.
    wait_d = (count_d >= CNT_WAIT);

    if (fifo_empty_s || pop_s) begin
      starve_d = STV_ZERO;
    end else if (vid_grant_s && (starve_q != STV_MAX)) begin
      starve_d = starve_q + STV_ONE;
    end else begin
      starve_d = starve_q;
    end

    rv_d[0] = vid_grant_s;
    for (int i = 1; i < RAM_LAT; i++) begin
      rv_d[i] = rv_q[i-1];
    end
    hold_d = rv_q[RAM_LAT-1] ? ram_rdata : hold_q;
  end

  // Download lifecycle: IDLE -> LOAD -> FLUSH -> DONE
  always_comb begin
    state_d    = state_q;
    got_data_d = got_data_q || push_s;
    case (state_q)
      ST_IDLE: begin
        got_data_d = push_s;
        if (rise_s && idx_match_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (rise_s && idx_match_s) begin
          // Reload before the drain finished: the loads merge into one dl_done.
          state_d = ST_LOAD;
        end else if (fifo_empty_s) begin
          // A load that never pushed anything finishes silently.
          state_d    = got_data_q ? ST_DONE : ST_IDLE;
          got_data_d = 1'b0;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        got_data_d = push_s;
        if (rise_s && idx_match_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        got_data_d = 1'b0;
      end
    endcase
  end

  // State, FIFO storage, pointers and read-return pipeline
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= CNT_ZERO;
      wait_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dl_prev_q   <= 1'b0;
      got_data_q  <= 1'b0;
      last_addr_q <= {ADDR_W{1'b0}};
      hold_q      <= {DATA_W{1'b0}};
      rv_q        <= {RAM_LAT{1'b0}};
      starve_q    <= STV_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= {ADDR_W{1'b0}};
        fifo_data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      ovf_q       <= ovf_d;
      dl_prev_q   <= ioctl_download;
      got_data_q  <= got_data_d;
      last_addr_q <= ram_addr_s;
      hold_q      <= hold_d;
      rv_q        <= rv_d;
      starve_q    <= starve_d;
      if (push_s) begin
        fifo_addr_q[wr_ptr_q] <= ioctl_addr[ADDR_W-1:0];
        fifo_data_q[wr_ptr_q] <= DATA_W'(ioctl_dout);
      end
    end
  end

  assign ioctl_wait  = wait_q;
  assign vid_ack     = vid_grant_s;
  assign vid_rvalid  = rv_q[RAM_LAT-1];
  assign vid_rdata   = rv_q[RAM_LAT-1] ? ram_rdata : hold_q;
  assign ram_addr    = ram_addr_s;
  assign ram_we      = pop_s;
  assign ram_wdata   = ram_wdata_s;
  assign dl_done     = (state_q == ST_DONE);
  assign dl_overflow = ovf_q;

endmodule

// File: tb/tb_ioctl_ram_arbiter.sv
module tb_ioctl_ram_arbiter;

  localparam int RAM_LAT = 2;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wait;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = 16'd0;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        vid_rvalid;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        dl_done;
  logic        dl_overflow;
  logic [7:0]  ram_p1;

  ioctl_ram_arbiter #(
    .ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4), .RAM_LAT(RAM_LAT),
    .DL_INDEX(8'd0), .MAX_STARVE(8)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dl_done(dl_done), .dl_overflow(dl_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Read contents of the modelled RAM; tests never read an address they write.
  function automatic logic [7:0] ram_model(input logic [15:0] a);
    if (a == 16'h0010) return 8'hA5;
    else return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Two-cycle read latency RAM model
  always_ff @(posedge clk_sys) begin
    ram_p1    <= ram_model(ram_addr);
    ram_rdata <= ram_p1;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_seen = 0;
  int          rvalid_seen = 0;
  logic [23:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  int          rd_cyc_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, a read return or dl_done
  initial begin : monitor
    logic [23:0] e;
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (!reset) begin
        if (ram_we) begin
          if (exp_wr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", ram_addr, ram_wdata);
          end else begin
            e = exp_wr_q.pop_front();
            check("wr_addr", {16'd0, ram_addr}, {16'd0, e[23:8]});
            check("wr_data", {24'd0, ram_wdata}, {24'd0, e[7:0]});
          end
        end
        if (vid_ack) begin
          check("ack_needs_req", {31'd0, vid_req}, 32'd1);
          exp_rd_q.push_back(ram_model(vid_addr));
          rd_cyc_q.push_back(cyc);
        end
        if (vid_rvalid) begin
          rvalid_seen++;
          if (exp_rd_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_rvalid: got data 0x%0h, required no rvalid", vid_rdata);
          end else begin
            check("rd_data", {24'd0, vid_rdata}, {24'd0, exp_rd_q.pop_front()});
            check("rd_latency", cyc - rd_cyc_q.pop_front(), RAM_LAT);
          end
        end
        if (dl_done) begin
          done_seen++;
          check("done_after_writes", exp_wr_q.size(), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input logic exp_accept);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    if (exp_accept) exp_wr_q.push_back({a[15:0], d});
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic vid_read(input logic [15:0] a);
    int n = 0;
    vid_req = 1'b1; vid_addr = a;
    @(negedge clk_sys);
    while (!vid_ack && n < 20) begin @(negedge clk_sys); n++; end
    check("ack_same_cycle", n, 32'd0);
    @(posedge clk_sys); #1;
    vid_req = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string name);
    int n = 0;
    while (done_seen == prev && n < 40) begin tick(); n++; end
    check(name, done_seen - prev, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  initial begin : stimulus
    int d0, r0, wr_cyc;
    logic wr_ack;

    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst_wait",   {31'd0, ioctl_wait}, 32'd0);
    check("rst_ack",    {31'd0, vid_ack}, 32'd0);
    check("rst_rvalid", {31'd0, vid_rvalid}, 32'd0);
    check("rst_rdata",  {24'd0, vid_rdata}, 32'd0);
    check("rst_addr",   {16'd0, ram_addr}, 32'd0);
    check("rst_we",     {31'd0, ram_we}, 32'd0);
    check("rst_wdata",  {24'd0, ram_wdata}, 32'd0);
    check("rst_done",   {31'd0, dl_done}, 32'd0);
    check("rst_ovf",    {31'd0, dl_overflow}, 32'd0);

    // Video reads
    r0 = rvalid_seen;
    vid_read(16'h0010);
    repeat (4) tick();
    check("rd_a5_held", {24'd0, vid_rdata}, 32'h0000_00A5);
    check("rd_one_pulse", rvalid_seen - r0, 32'd1);
    vid_read(16'h0020);
    repeat (4) tick();
    check("rd_1c_held", {24'd0, vid_rdata}, 32'h0000_001C);
    check("idle_addr_hold", {16'd0, ram_addr}, 32'h0000_0020);
    check("rd_two_pulses", rvalid_seen - r0, 32'd2);

    // 16-byte download, no video traffic
    d0 = done_seen;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("dl_wait_clear", {31'd0, ioctl_wait}, 32'd0);
      strobe(25'(i), 8'(i * 9 + 1), 1'b1);
    end
    ioctl_download = 1'b0;
    wait_done(d0, "dl16_done");
    repeat (5) tick();
    check("dl16_single_done", done_seen - d0, 32'd1);
    check("dl16_drained", exp_wr_q.size(), 32'd0);
    check("dl16_no_ovf", {31'd0, dl_overflow}, 32'd0);

    // Overflow under continuous video reads
    d0 = done_seen;
    vid_req = 1'b1; vid_addr = 16'h0030;
    ioctl_download = 1'b1;
    strobe(25'h100, 8'hB0, 1'b1);
    strobe(25'h101, 8'hB1, 1'b1);
    check("ovf_wait_after2", {31'd0, ioctl_wait}, 32'd0);
    strobe(25'h102, 8'hB2, 1'b1);
    check("ovf_wait_after3", {31'd0, ioctl_wait}, 32'd1);
    strobe(25'h103, 8'hB3, 1'b1);
    strobe(25'h104, 8'hB4, 1'b0);
    check("ovf_flag", {31'd0, dl_overflow}, 32'd1);
    check("ovf_pending", exp_wr_q.size(), 32'd4);
    ioctl_download = 1'b0;
    vid_req = 1'b0;
    wait_done(d0, "ovf_done");
    repeat (3) tick();
    check("ovf_drained", exp_wr_q.size(), 32'd0);
    check("ovf_wait_low", {31'd0, ioctl_wait}, 32'd0);
    check("ovf_sticky", {31'd0, dl_overflow}, 32'd1);

    // Rejected strobes: wrong index, address out of range
    d0 = done_seen;
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    strobe(25'h5, 8'h11, 1'b0);
    strobe(25'h6, 8'h12, 1'b0);
    ioctl_download = 1'b0;
    repeat (3) tick();
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    strobe(25'h10000, 8'h22, 1'b0);
    strobe(25'h1FFFF, 8'h23, 1'b0);
    ioctl_download = 1'b0;
    repeat (10) tick();
    check("rej_no_done", done_seen - d0, 32'd0);
    check("rej_wait_low", {31'd0, ioctl_wait}, 32'd0);
    check("rej_we_low", {31'd0, ram_we}, 32'd0);

    // One queued byte under continuous video reads
    d0 = done_seen;
    vid_req = 1'b1; vid_addr = 16'h0040;
    tick();
    ioctl_download = 1'b1;
    strobe(25'h200, 8'h5E, 1'b1);
    ioctl_download = 1'b0;
    wr_cyc = 0; wr_ack = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_sys);
      if (ram_we && wr_cyc == 0) begin wr_cyc = c; wr_ack = vid_ack; end
    end
`ifdef IOCTL_RAM_ARB_STARVE_GUARD_EN
    check("starve_write_cycle", wr_cyc, 32'd9);
    check("starve_ack_low", {31'd0, wr_ack}, 32'd0);
`else
    check("starve_never_written", wr_cyc, 32'd0);
`endif
    @(posedge clk_sys); #1;
    vid_req = 1'b0;
    wait_done(d0, "starve_done");
    check("starve_drained", exp_wr_q.size(), 32'd0);

    // Reset in the middle of a download
    d0 = done_seen;
    vid_req = 1'b1; vid_addr = 16'h0050;
    ioctl_download = 1'b1;
    strobe(25'h300, 8'hC0, 1'b0);
    strobe(25'h301, 8'hC1, 1'b0);
    reset = 1'b1; vid_req = 1'b0;
    exp_rd_q.delete(); rd_cyc_q.delete();
    repeat (2) tick();
    ioctl_download = 1'b0;
    reset = 1'b0;
    repeat (10) tick();
    check("mid_rst_no_done", done_seen - d0, 32'd0);
    check("mid_rst_ovf_clr", {31'd0, dl_overflow}, 32'd0);
    check("mid_rst_wait_low", {31'd0, ioctl_wait}, 32'd0);
    check("mid_rst_we_low", {31'd0, ram_we}, 32'd0);

    check("final_wr_empty", exp_wr_q.size(), 32'd0);
    check("final_rd_empty", exp_rd_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
